// File: rtl/stream_rsp_router.sv
// Response return path behind a stream_xbar output: forwards requests and steers in-order
// responses back to their originating input. Optional macro: STREAM_RSP_ROUTER_FULL_BYPASS_EN.
module stream_rsp_router #(
  parameter int unsigned NumInp   = 0,
  parameter int unsigned ReqWidth = 1,
  parameter int unsigned RspWidth = 1,
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [ReqWidth-1:0]          req_data_i,
  input  logic [IdxWidth-1:0]          req_idx_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  output logic [ReqWidth-1:0]          req_data_o,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  input  logic [RspWidth-1:0]          rsp_data_i,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  output logic [NumInp*RspWidth-1:0]   rsp_data_o,
  output logic [NumInp-1:0]            rsp_valid_o,
  input  logic [NumInp-1:0]            rsp_ready_i,
  output logic [CntWidth-1:0]          outstanding_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  logic [IdxWidth-1:0] idx_mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;
  logic [IdxWidth-1:0] head;
  logic                full;
  logic                empty;
  logic                room;
  logic                push;
  logic                pop;
  logic                head_ready;

  assign full  = (count == FullCnt);
  assign empty = (count == '0);
  assign head  = idx_mem[rd_ptr];

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_ready = 1'b0;
    for (int k = 0; k < NumInp; k++) begin
      if (head == IdxWidth'(k)) head_ready = rsp_ready_i[k];
    end
  end

  assign rsp_ready_o = ~empty & head_ready;
  assign pop         = rsp_valid_i & rsp_ready_o;

`ifdef STREAM_RSP_ROUTER_FULL_BYPASS_EN
  assign room = ~full | pop;
`else
  assign room = ~full;
`endif

  assign req_data_o  = req_data_i;
  assign req_valid_o = req_valid_i & room;
  assign req_ready_o = req_ready_i & room;
  assign push        = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) idx_mem[i] <= '0;
    end else if (push && !flush_i) begin
      idx_mem[wr_ptr] <= req_idx_i;
    end
  end

  for (genvar k = 0; k < NumInp; k++) begin : g_rsp_out
    assign rsp_data_o[k*RspWidth +: RspWidth] = rsp_data_i;
    assign rsp_valid_o[k] = rsp_valid_i & ~empty & (head == IdxWidth'(k));
  end

  assign outstanding_o = count;

`ifndef SYNTHESIS
  logic                req_stall_q;
  logic                rsp_stall_q;
  logic [ReqWidth-1:0] req_data_q;
  logic [IdxWidth-1:0] req_idx_q;
  logic [RspWidth-1:0] rsp_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_stall_q <= 1'b0;
      rsp_stall_q <= 1'b0;
      req_data_q  <= '0;
      req_idx_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      req_stall_q <= req_valid_i & ~req_ready_o;
      rsp_stall_q <= rsp_valid_i & ~rsp_ready_o;
      req_data_q  <= req_data_i;
      req_idx_q   <= req_idx_i;
      rsp_data_q  <= rsp_data_i;
    end
  end

  // Sampled at the edge, so the *_q registers still hold the previous cycle here.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (req_valid_i)
        assert (32'(req_idx_i) < NumInp) else $error("req_idx_i out of range");
      if (rsp_valid_i)
        assert (!empty) else $error("response with no outstanding request");
      if (req_stall_q)
        assert (req_valid_i && req_data_i == req_data_q && req_idx_i == req_idx_q)
          else $error("request changed while stalled");
      if (rsp_stall_q)
        assert (rsp_valid_i && rsp_data_i == rsp_data_q)
          else $error("response changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_stream_rsp_router.sv
// Bench for stream_rsp_router: directed vector table, corner sequences and a
// randomized run against a queue-based model of the in-order index tracker.
module tb_stream_rsp_router;

  localparam int NumInp = 4;
  localparam int Depth  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush, req_valid, req_ready_in, rsp_valid;
  logic [1:0]  req_idx;
  logic [7:0]  req_data, rsp_data;
  logic [3:0]  rsp_ready_in;
  logic        req_ready_out, req_valid_out, rsp_ready_out;
  logic [7:0]  req_data_out;
  logic [31:0] rsp_data_out;
  logic [3:0]  rsp_valid_out;
  logic [2:0]  outstanding;

  logic        w_flush, w_req_valid, w_req_ready_in, w_rsp_valid;
  logic [1:0]  w_req_idx;
  logic [7:0]  w_req_data, w_rsp_data;
  logic [3:0]  w_rsp_ready_in;
  logic        w_req_ready_out, w_req_valid_out, w_rsp_ready_out;
  logic [7:0]  w_req_data_out;
  logic [31:0] w_rsp_data_out;
  logic [3:0]  w_rsp_valid_out;
  logic [1:0]  w_outstanding;

  stream_rsp_router #(.NumInp(NumInp), .ReqWidth(8), .RspWidth(8), .Depth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_data_i(req_data), .req_idx_i(req_idx), .req_valid_i(req_valid), .req_ready_o(req_ready_out),
    .req_data_o(req_data_out), .req_valid_o(req_valid_out), .req_ready_i(req_ready_in),
    .rsp_data_i(rsp_data), .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_out),
    .rsp_data_o(rsp_data_out), .rsp_valid_o(rsp_valid_out), .rsp_ready_i(rsp_ready_in),
    .outstanding_o(outstanding)
  );

  stream_rsp_router #(.NumInp(NumInp), .ReqWidth(8), .RspWidth(8), .Depth(3)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(w_flush),
    .req_data_i(w_req_data), .req_idx_i(w_req_idx), .req_valid_i(w_req_valid), .req_ready_o(w_req_ready_out),
    .req_data_o(w_req_data_out), .req_valid_o(w_req_valid_out), .req_ready_i(w_req_ready_in),
    .rsp_data_i(w_rsp_data), .rsp_valid_i(w_rsp_valid), .rsp_ready_o(w_rsp_ready_out),
    .rsp_data_o(w_rsp_data_out), .rsp_valid_o(w_rsp_valid_out), .rsp_ready_i(w_rsp_ready_in),
    .outstanding_o(w_outstanding)
  );

  int tests = 0;
  int fails = 0;
  int q[$];
  logic req_hold = 1'b0;
  logic rsp_hold = 1'b0;

  typedef struct {
    logic       req_valid;
    logic [1:0] req_idx;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [3:0] rsp_ready_in;
    logic [2:0] exp_out;
    logic       exp_req_valid;
    logic       exp_req_ready;
    logic [3:0] exp_rsp_valid;
    logic       exp_rsp_ready;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic rv, input logic [1:0] ri, input logic rri,
                               input logic sv, input logic [7:0] sd, input logic [3:0] sri);
    flush        = f;
    req_valid    = rv;
    req_idx      = ri;
    req_data     = {6'h14, ri};
    req_ready_in = rri;
    rsp_valid    = sv;
    rsp_data     = sd;
    rsp_ready_in = sri;
  endtask

  // Model: a response goes to the oldest tracked index; requests need a free slot.
  task automatic computeExpect(output logic [3:0] e_vld, output logic e_rdy, output logic e_rv,
                               output logic e_rr, output logic e_pop, output logic e_push);
    logic nonempty;
    logic room;
    int   head;
    nonempty = (q.size() > 0);
    head     = nonempty ? q[0] : 0;
    e_vld    = (rsp_valid && nonempty) ? 4'(1 << head) : 4'b0;
    e_rdy    = nonempty && rsp_ready_in[head];
    e_pop    = rsp_valid && e_rdy;
    room     = (q.size() < Depth);
`ifdef STREAM_RSP_ROUTER_FULL_BYPASS_EN
    room     = room || e_pop;
`endif
    e_rv     = req_valid && room;
    e_rr     = req_ready_in && room;
    e_push   = req_valid && e_rr;
  endtask

  task automatic modelUpdate();
    logic [3:0] e_vld;
    logic e_rdy, e_rv, e_rr, e_pop, e_push;
    computeExpect(e_vld, e_rdy, e_rv, e_rr, e_pop, e_push);
    req_hold = req_valid && !e_rr;
    rsp_hold = rsp_valid && !e_rdy;
    if (flush) begin
      q.delete();
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_push) q.push_back(int'(req_idx));
    end
  endtask

  task automatic checkAll(input string name);
    logic [3:0] e_vld;
    logic e_rdy, e_rv, e_rr, e_pop, e_push;
    computeExpect(e_vld, e_rdy, e_rv, e_rr, e_pop, e_push);
    checkOutput({name, "_outstanding"}, 32'(outstanding), 32'(q.size()));
    checkOutput({name, "_rsp_valid"}, 32'(rsp_valid_out), 32'(e_vld));
    checkOutput({name, "_rsp_ready"}, 32'(rsp_ready_out), 32'(e_rdy));
    checkOutput({name, "_req_valid"}, 32'(req_valid_out), 32'(e_rv));
    checkOutput({name, "_req_ready"}, 32'(req_ready_out), 32'(e_rr));
    checkOutput({name, "_req_data"}, 32'(req_data_out), 32'(req_data));
    checkOutput({name, "_rsp_data"}, rsp_data_out, {4{rsp_data}});
  endtask

  task automatic step(input string name);
    @(negedge clk);
    checkAll(name);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0);
    w_flush = 1'b0; w_req_valid = 1'b0; w_req_idx = 2'd0; w_req_data = 8'h00;
    w_req_ready_in = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 8'h00; w_rsp_ready_in = 4'hF;

    #12;
    checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
    checkOutput("reset_rsp_ready", 32'(rsp_ready_out), 32'd0);
    checkOutput("reset_wrap_outstanding", 32'(w_outstanding), 32'd0);
    req_valid = 1'b1; req_ready_in = 1'b1; rsp_valid = 1'b1; rsp_ready_in = 4'hF;
    #1;
    checkOutput("reset_req_valid", 32'(req_valid_out), 32'd1);
    checkOutput("reset_req_ready", 32'(req_ready_out), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // In-order routing, then fill to full and release one slot, then head back-pressure.
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 4'hF, 3'd0, 1'b1, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 8'h00, 4'hF, 3'd1, 1'b1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8'h00, 4'hF, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0A, 4'hF, 3'd3, 1'b0, 1'b1, 4'b0100, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0B, 4'hF, 3'd2, 1'b0, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0C, 4'hF, 3'd1, 1'b0, 1'b1, 4'b1000, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 8'h00, 4'hF, 3'd0, 1'b1, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 4'hF, 3'd1, 1'b1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 8'h00, 4'hF, 3'd2, 1'b1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 4'hF, 3'd3, 1'b1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 4'hF, 3'd4, 1'b0, 1'b0, 4'b0000, 1'b1});
`ifdef STREAM_RSP_ROUTER_FULL_BYPASS_EN
    vecs.push_back('{1'b1, 2'd2, 1'b1, 8'h0D, 4'hF, 3'd4, 1'b1, 1'b1, 4'b0001, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 3'd4, 1'b0, 1'b0, 4'b0000, 1'b1});
`else
    vecs.push_back('{1'b1, 2'd2, 1'b1, 8'h0D, 4'hF, 3'd4, 1'b0, 1'b0, 4'b0001, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 4'hF, 3'd3, 1'b1, 1'b1, 4'b0000, 1'b1});
`endif
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 3'd4, 1'b0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0E, 4'hD, 3'd4, 1'b0, 1'b0, 4'b0010, 1'b0});
`ifdef STREAM_RSP_ROUTER_FULL_BYPASS_EN
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0E, 4'hF, 3'd4, 1'b0, 1'b1, 4'b0010, 1'b1});
`else
    vecs.push_back('{1'b0, 2'd0, 1'b1, 8'h0E, 4'hF, 3'd4, 1'b0, 1'b0, 4'b0010, 1'b1});
`endif
    vecs.push_back('{1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 3'd3, 1'b0, 1'b1, 4'b0000, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].req_valid, vecs[i].req_idx, 1'b1,
                    vecs[i].rsp_valid, vecs[i].rsp_data, vecs[i].rsp_ready_in);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(vecs[i].exp_out));
      checkOutput($sformatf("vec%0d_req_valid", i), 32'(req_valid_out), 32'(vecs[i].exp_req_valid));
      checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready_out), 32'(vecs[i].exp_req_ready));
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid_out), 32'(vecs[i].exp_rsp_valid));
      checkOutput($sformatf("vec%0d_rsp_ready", i), 32'(rsp_ready_out), 32'(vecs[i].exp_rsp_ready));
      checkOutput($sformatf("vec%0d_rsp_data", i), rsp_data_out, {4{vecs[i].rsp_data}});
      @(posedge clk);
      modelUpdate();
      #1;
    end

    for (int g = 0; g < 10 && q.size() > 0; g++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 8'(8'h40 + g), 4'hF);
      step("drain");
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'hF);
    checkOutput("drained_outstanding", 32'(outstanding), 32'd0);

    // A response offered while nothing is outstanding is withdrawn before the edge.
    rsp_valid = 1'b1;
    rsp_data  = 8'h77;
    #1;
    checkOutput("empty_rsp_ready", 32'(rsp_ready_out), 32'd0);
    checkOutput("empty_rsp_valid", 32'(rsp_valid_out), 32'd0);
    rsp_valid = 1'b0;
    @(posedge clk);
    modelUpdate();
    #1;

    // Depth-3 instance: overlapped push/pop pairs across pointer wrap.
    for (int i = 0; i <= 10; i++) begin
      w_req_valid = (i < 10);
      w_req_idx   = 2'(i % 4);
      w_req_data  = 8'(i);
      w_rsp_valid = (i > 0);
      w_rsp_data  = 8'(8'hA0 + i);
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("wrap%0d_rsp_valid", i), 32'(w_rsp_valid_out), 32'(1 << ((i - 1) % 4)));
        checkOutput($sformatf("wrap%0d_rsp_data", i), w_rsp_data_out, {4{8'(8'hA0 + i)}});
        checkOutput($sformatf("wrap%0d_outstanding", i), 32'(w_outstanding), 32'd1);
      end else begin
        checkOutput("wrap0_outstanding", 32'(w_outstanding), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    w_req_valid = 1'b0;
    w_rsp_valid = 1'b0;
    #1;
    checkOutput("wrap_end_outstanding", 32'(w_outstanding), 32'd0);

    // Asynchronous reset with two entries in flight.
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 4'hF);
    step("rst_push0");
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 4'hF);
    step("rst_push1");
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 8'h55, 4'h0);
    #1;
    checkAll("pre_reset");
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outstanding", 32'(outstanding), 32'd0);
    checkOutput("async_reset_rsp_valid", 32'(rsp_valid_out), 32'd0);
    q.delete();
    rsp_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    step("post_reset");

    // Flush beats a simultaneous push and takes effect on the next edge.
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 4'hF);
    step("flush_push0");
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 4'hF);
    step("flush_push1");
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 4'hF);
    step("flush");
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 4'hF);
    step("post_flush");
    checkOutput("flush_outstanding", 32'(outstanding), 32'd0);

    for (int n = 0; n < 400; n++) begin
      if (!req_hold) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_idx   = 2'($urandom_range(0, 3));
        req_data  = 8'($urandom);
      end
      if (!rsp_hold) begin
        rsp_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
        rsp_data  = 8'($urandom);
      end
      flush        = (q.size() == 0) && !rsp_hold && ($urandom_range(0, 19) == 0);
      req_ready_in = ($urandom_range(0, 3) != 0);
      rsp_ready_in = 4'($urandom) | 4'($urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_rsp_router.md
# stream_rsp_router

Response return path placed directly downstream of a `stream_xbar` output port. Each request leaving the crossbar output carries the index of its originating input. The block forwards that request to the target and records the index in an in-order tracking FIFO. Each returning response is then steered back to the originating input, in request order. Outstanding requests are capped at `Depth`.

## Interface
- `NumInp`, default 0: number of crossbar inputs that responses return to (> 0).
- `ReqWidth`, default 1: request payload width.
- `RspWidth`, default 1: response payload width.
- `Depth`, default 4: maximum number of outstanding requests (≥ 1, any value).
- `IdxWidth`, derived: `NumInp > 1 ? $clog2(NumInp) : 1`. Do not overwrite.
- `CntWidth`, derived: `$clog2(Depth+1)`. Do not overwrite.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active low.
- `flush_i`  in  1  synchronous clear of the tracking FIFO. Only legal with nothing in flight.
- `req_data_i`  in  ReqWidth  request payload from the crossbar output.
- `req_idx_i`  in  IdxWidth  originating input index from the crossbar output.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted.
- `req_data_o`  out  ReqWidth  request payload to the target.
- `req_valid_o`  out  1  request valid to the target.
- `req_ready_i`  in  1  target ready.
- `rsp_data_i`  in  RspWidth  response payload from the target.
- `rsp_valid_i`  in  1  response valid.
- `rsp_ready_o`  out  1  response accepted.
- `rsp_data_o`  out  NumInp×RspWidth  response payload, broadcast to all inputs.
- `rsp_valid_o`  out  NumInp  one-hot response valid.
- `rsp_ready_i`  in  NumInp  per-input response ready.
- `outstanding_o`  out  CntWidth  current FIFO occupancy.

## Operation
- **Storage.** Circular buffer of `Depth` entries, each `IdxWidth` bits wide.
  - Write pointer, read pointer and count are all registered.
  - Pointers wrap from `Depth-1` to 0. Non-power-of-two `Depth` is supported.
- **Flags.** `full = (count == Depth)`, `empty = (count == 0)`.
- **Request path.** Combinational pass-through, gated by `room`.
  - `req_data_o = req_data_i`
  - `req_valid_o = req_valid_i & room`
  - `req_ready_o = req_ready_i & room`
  - `room = ~full`, or as widened under Configuration.
- **Push.** Occurs when `req_valid_i & req_ready_o`. Writes `req_idx_i` at the write pointer.
- **Response path.** `head` is the FIFO entry at the read pointer.
  - `rsp_data_o[k] = rsp_data_i` for all k.
  - `rsp_valid_o[k] = rsp_valid_i & ~empty & (head == k)`.
  - `rsp_ready_o = ~empty & rsp_ready_i[head]`.
- **Pop.** Occurs when `rsp_valid_i & rsp_ready_o`.
- **Simultaneous push and pop.** Count is unchanged and both pointers advance.
- **Response while empty.** `rsp_ready_o = 0` and all `rsp_valid_o = 0`. The response stalls and is never dropped.
- **Flush.** Pointers and count go to 0 on the next edge. Flush has priority over push and pop in the same cycle.
- **Assertions** (non-synthesis):
  - `req_idx_i < NumInp` whenever `req_valid_i` is high.
  - `rsp_valid_i` high while empty raises an error.
  - AXI stability on req and rsp while valid is high and ready is low.

## Timing
- **Reset values.** Count = 0 and both pointers = 0.
  - Therefore `outstanding_o = 0`, `rsp_valid_o = 0`, `rsp_ready_o = 0`.
  - `req_valid_o` and `req_ready_o` follow their inputs, since room = 1 after reset.
- **Latency.**
  - Request: 0 cycles, combinational.
  - Index tracking: the index is visible at the head one cycle after the push edge. A response can therefore pop at the earliest one cycle after its request handshake.
- **Full.** The request is stalled: `req_valid_o = 0` and `req_ready_o = 0`. This holds until a pop frees an entry (or the same cycle, under Configuration).
- **Reset mid-operation.** All tracking is lost. Targets must also be reset.
- **Combinational paths.**
  - `req_ready_i` → `req_ready_o`.
  - `rsp_ready_i[head]` → `rsp_ready_o`.
  - No path from `rsp_*` to `req_*`, unless the Configuration macro is defined.

## Configuration
- **Macro:** `STREAM_RSP_ROUTER_FULL_BYPASS_EN`.
- **Defined:** `room = ~full | pop`. When full, a request is accepted in the same cycle as a popping response, so occupancy stays at `Depth`. This adds the combinational path `rsp_valid_i`/`rsp_ready_i` → `req_valid_o`/`req_ready_o`.
- **Undefined:** `room = ~full`. A full FIFO needs one cycle after a pop before the next request is accepted.

## Test plan
1. **In-order routing.** `NumInp=4`, `Depth=4`. Push idx 2, 0, 3, then send responses 0xA, 0xB, 0xC. Required: `rsp_valid_o` goes 0b0100, 0b0001, 0b1000 carrying 0xA, 0xB, 0xC. `outstanding_o` goes 3→0.
2. **Full stall.** Push 4 requests with no responses. Required: `outstanding_o = 4`; a fifth request sees `req_ready_o = 0` and `req_valid_o = 0`. One response pops, then the fifth request is accepted on the next cycle (macro undefined) or in the same cycle (macro defined).
3. **Empty response.** Assert `rsp_valid_i` with count 0. Required: `rsp_ready_o = 0`, `rsp_valid_o = 0`, and the error assertion fires.
4. **Back-pressure on head.** Head idx = 1 with `rsp_ready_i[1] = 0` and the others at 1. Required: `rsp_ready_o = 0` and count stays unchanged. Raising `rsp_ready_i[1]` pops the entry in that cycle.
5. **Non-power-of-two wrap.** `Depth=3`. Run 10 push/pop pairs with idx values 0..9 mod `NumInp`. Required: every response routes correctly across pointer wrap 2→0.
6. **Reset/flush.** With 2 entries outstanding, assert `rst_ni = 0` asynchronously. Required: `outstanding_o = 0` and `rsp_valid_o = 0` immediately. Repeat with `flush_i`: both take effect on the next edge.
